// File: rtl/tpu_instr_fetch_if.sv
// tpu_instr_fetch_if: bundles the host write port, the controller-side fetch
// controls and the IR outputs of tpu_instr_fetch.
//   host_wr_en/addr/data : host writes into the instruction RAM
//   start/start_pc       : begin fetching at start_pc
//   pc_cnt, pc_ld(+addr), ir_ld, if_id_flush, pipeline_stall, halt_req :
//                          fetch controls from tpu_controller
//   instr_data/valid, ir_pc, busy, done, wr_err : fetch stage outputs
// master drives the controls (host/controller side); slave is the fetch stage.
interface tpu_instr_fetch_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              host_wr_en;
  logic [ADDR_W-1:0] host_wr_addr;
  logic [31:0]       host_wr_data;
  logic              start;
  logic [ADDR_W-1:0] start_pc;
  logic              pc_cnt;
  logic              pc_ld;
  logic [ADDR_W-1:0] pc_ld_addr;
  logic              ir_ld;
  logic              if_id_flush;
  logic              pipeline_stall;
  logic              halt_req;
  logic [31:0]       instr_data;
  logic              instr_valid;
  logic [ADDR_W-1:0] ir_pc;
  logic              busy;
  logic              done;
  logic              wr_err;

  modport master (
    output host_wr_en, host_wr_addr, host_wr_data, start, start_pc, pc_cnt,
           pc_ld, pc_ld_addr, ir_ld, if_id_flush, pipeline_stall, halt_req,
    input  instr_data, instr_valid, ir_pc, busy, done, wr_err
  );

  modport slave (
    input  host_wr_en, host_wr_addr, host_wr_data, start, start_pc, pc_cnt,
           pc_ld, pc_ld_addr, ir_ld, if_id_flush, pipeline_stall, halt_req,
    output instr_data, instr_valid, ir_pc, busy, done, wr_err
  );
endinterface

// File: rtl/tpu_instr_fetch.sv
// tpu_instr_fetch: instruction fetch stage feeding tpu_controller. Holds the
// host-loaded instruction RAM, the fetch PC, a 2-entry prefetch buffer and the
// instruction register.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset (RAM contents are preserved)
//   bus   : tpu_instr_fetch_if.slave (host writes, fetch controls, IR outputs)
module tpu_instr_fetch #(
  parameter int unsigned ADDR_W = 8
) (
  input logic              clk,
  input logic              rst_n,
  tpu_instr_fetch_if.slave bus
);
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic [ADDR_W-1:0] r_pc;
  logic              r_epoch;
  logic              r_inf_valid;
  logic              r_inf_epoch;
  logic [ADDR_W-1:0] r_inf_addr;
  logic [DATA_W-1:0] r_buf_data [2];
  logic [ADDR_W-1:0] r_buf_addr [2];
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_ir;
  logic [ADDR_W-1:0] r_ir_pc;
  logic              r_instr_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_wr_err;

  logic              w_run;
  logic              w_start;
  logic              w_halt;
  logic              w_flush;
  logic              w_clear;
  logic              w_ir_try;
  logic              w_pop;
  logic              w_arrive;
  logic              w_push;
  logic              w_push_hi;
  logic              w_issue;
  logic [2:0]        w_occ;

  // Event decode in priority order: start (outside RUN) > halt > redirect/flush > IR load > issue.
  assign w_run     = (r_state == S_RUN);
  assign w_start   = bus.start && !w_run;
  assign w_halt    = bus.halt_req && w_run;
  assign w_flush   = (bus.pc_ld || bus.if_id_flush) && !w_start && !w_halt;
  assign w_clear   = w_start || w_halt || w_flush;
  assign w_ir_try  = bus.ir_ld && !bus.pipeline_stall && !w_clear;
  assign w_pop     = w_ir_try && (r_cnt != 2'd0);
  // Returning read is live only if no flush happened since it was issued.
  assign w_arrive  = r_inf_valid && (r_inf_epoch == r_epoch);
  assign w_push    = w_arrive && !w_clear;
  assign w_occ     = 3'(r_cnt) + 3'(w_arrive) - 3'(w_pop);
  assign w_issue   = w_run && bus.pc_cnt && !bus.halt_req && !bus.pc_ld &&
                     !bus.if_id_flush && (w_occ < 3'd2);
  // Arriving word lands behind whatever survives this edge's pop.
  assign w_push_hi = (r_cnt == 2'd2) || ((r_cnt == 2'd1) && !w_pop);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_HALTED: if (bus.start)    w_state_nxt = S_RUN;
      S_RUN:            if (bus.halt_req) w_state_nxt = S_HALTED;
      default:                            w_state_nxt = S_IDLE;
    endcase
  end

  // Instruction RAM: host writes outside RUN, synchronous read on issue.
  always_ff @(posedge clk) begin
    if (rst_n && bus.host_wr_en && !w_run) r_mem[bus.host_wr_addr] <= bus.host_wr_data;
    if (w_issue) r_rd_data <= r_mem[r_pc];
  end

  // Fetch PC, in-flight tag, prefetch buffer, IR and status flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc          <= '0;
      r_epoch       <= 1'b0;
      r_inf_valid   <= 1'b0;
      r_inf_epoch   <= 1'b0;
      r_inf_addr    <= '0;
      r_cnt         <= 2'd0;
      r_buf_data[0] <= '0;
      r_buf_data[1] <= '0;
      r_buf_addr[0] <= '0;
      r_buf_addr[1] <= '0;
      r_ir          <= '0;
      r_ir_pc       <= '0;
      r_instr_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_wr_err      <= 1'b0;
    end else begin
      r_busy      <= (w_state_nxt == S_RUN);
      r_done      <= w_halt;
      r_wr_err    <= bus.host_wr_en && w_run;
      r_inf_valid <= w_issue;
      if (w_issue) begin
        r_inf_addr  <= r_pc;
        r_inf_epoch <= r_epoch;
      end

      if (w_start)                 r_pc <= bus.start_pc;
      else if (!w_halt && bus.pc_ld) r_pc <= bus.pc_ld_addr;
      else if (w_issue)            r_pc <= r_pc + ADDR_W'(1);

      if (w_flush) r_epoch <= ~r_epoch;

      if (w_clear) begin
        r_cnt <= 2'd0;
      end else begin
        if (w_pop) begin
          r_buf_data[0] <= r_buf_data[1];
          r_buf_addr[0] <= r_buf_addr[1];
        end
        if (w_push) begin
          if (w_push_hi) begin
            r_buf_data[1] <= r_rd_data;
            r_buf_addr[1] <= r_inf_addr;
          end else begin
            r_buf_data[0] <= r_rd_data;
            r_buf_addr[0] <= r_inf_addr;
          end
        end
        r_cnt <= 2'(w_occ);
      end

      if (w_start) begin
        r_ir          <= '0;
        r_ir_pc       <= '0;
        r_instr_valid <= 1'b0;
      end else if (w_flush) begin
        r_ir          <= '0;
        r_instr_valid <= 1'b0;
      end else if (w_ir_try) begin
        if (w_pop) begin
          r_ir          <= r_buf_data[0];
          r_ir_pc       <= r_buf_addr[0];
          r_instr_valid <= 1'b1;
        end else begin
          r_instr_valid <= 1'b0;
        end
      end
    end
  end

  assign bus.instr_data  = r_ir;
  assign bus.instr_valid = r_instr_valid;
  assign bus.ir_pc       = r_ir_pc;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.wr_err      = r_wr_err;
endmodule

// File: tb/tb_tpu_instr_fetch.sv
// Testbench for tpu_instr_fetch: directed scenarios plus a randomized run,
// all compared against a queue-based behavioural model of the fetch stage.
module tb_tpu_instr_fetch;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned VEC_W  = 36 + ADDR_W;
  localparam int M_IDLE = 0, M_RUN = 1, M_HALTED = 2;
  localparam logic [31:0] WORDS [4] = '{32'h40000000, 32'h40000004, 32'h40000008, 32'hFC000000};

  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  tpu_instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();
  tpu_instr_fetch #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Behavioural model: RAM image, fetch queue of addresses, at most one read in flight.
  logic [31:0]       gmem [DEPTH];
  int                m_state = M_IDLE;
  logic [ADDR_W-1:0] m_pc = '0;
  logic [ADDR_W-1:0] m_irpc = '0;
  logic [31:0]       m_ir = '0;
  logic              m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_werr = 1'b0;
  logic [ADDR_W-1:0] m_buf [$];
  logic [ADDR_W-1:0] m_infl [$];

  function automatic void model_step();
    logic [ADDR_W-1:0] a;
    int occ;
    int pop;
    m_done = 1'b0;
    m_werr = 1'b0;
    if (!rst_n) begin
      m_state = M_IDLE; m_pc = '0; m_buf.delete(); m_infl.delete();
      m_ir = '0; m_valid = 1'b0; m_irpc = '0; m_busy = 1'b0;
      return;
    end
    if (bus.host_wr_en) begin
      if (m_state != M_RUN) gmem[bus.host_wr_addr] = bus.host_wr_data;
      else m_werr = 1'b1;
    end
    if (m_state != M_RUN && bus.start) begin
      m_state = M_RUN; m_pc = bus.start_pc; m_buf.delete(); m_infl.delete();
      m_ir = '0; m_valid = 1'b0; m_irpc = '0;
    end else if (m_state == M_RUN && bus.halt_req) begin
      m_state = M_HALTED; m_done = 1'b1; m_buf.delete(); m_infl.delete();
    end else if (bus.pc_ld || bus.if_id_flush) begin
      m_buf.delete(); m_infl.delete(); m_ir = '0; m_valid = 1'b0;
      if (bus.pc_ld) m_pc = bus.pc_ld_addr;
    end else begin
      occ = m_buf.size() + m_infl.size();
      pop = 0;
      if (bus.ir_ld && !bus.pipeline_stall) begin
        if (m_buf.size() > 0) begin
          a = m_buf.pop_front();
          m_ir = gmem[a]; m_irpc = a; m_valid = 1'b1; pop = 1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (m_infl.size() > 0) m_buf.push_back(m_infl.pop_front());
      if (m_state == M_RUN && bus.pc_cnt && (occ - pop) < 2) begin
        m_infl.push_back(m_pc);
        m_pc = m_pc + ADDR_W'(1);
      end
    end
    m_busy = (m_state == M_RUN);
  endfunction

  function automatic logic [VEC_W-1:0] exp_vec();
    return {m_ir, m_valid, m_irpc, m_busy, m_done, m_werr};
  endfunction

  function automatic logic [VEC_W-1:0] dut_vec();
    return {bus.instr_data, bus.instr_valid, bus.ir_pc, bus.busy, bus.done, bus.wr_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_idle();
    bus.host_wr_en = 1'b0; bus.host_wr_addr = '0; bus.host_wr_data = '0;
    bus.start = 1'b0; bus.start_pc = '0; bus.pc_cnt = 1'b0;
    bus.pc_ld = 1'b0; bus.pc_ld_addr = '0; bus.ir_ld = 1'b0;
    bus.if_id_flush = 1'b0; bus.pipeline_stall = 1'b0; bus.halt_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_idle();
    tick();
    tick();
    checks++;
    if (dut_vec() !== '0) begin
      errors++; $display("FAIL reset_values: got %h want 0", dut_vec());
    end
    checks++;
    if (dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL reset_model: got %h want %h", dut_vec(), exp_vec());
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_run();
    bus.host_wr_en = 1'b1;
    for (int k = 0; k < int'(DEPTH); k++) begin
      bus.host_wr_addr = ADDR_W'(k);
      bus.host_wr_data = $urandom;
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      bus.host_wr_addr = ADDR_W'(k);
      bus.host_wr_data = WORDS[k];
      tick();
    end
    bus.host_wr_en = 1'b0;
    bus.ir_ld = 1'b1; bus.pc_cnt = 1'b1;
    bus.start = 1'b1; bus.start_pc = '0;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL load_run_model cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (i < 3) begin
        checks++;
        if (bus.instr_valid !== 1'b0) begin
          errors++; $display("FAIL load_run_latency cyc %0d: valid got %b want 0", i, bus.instr_valid);
        end
      end else if (i <= 6) begin
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.ir_pc !== ADDR_W'(i - 3) || bus.instr_data !== WORDS[i - 3]) begin
          errors++; $display("FAIL load_run_seq cyc %0d: got v=%b pc=%h d=%h want v=1 pc=%h d=%h",
                             i, bus.instr_valid, bus.ir_pc, bus.instr_data, ADDR_W'(i - 3), WORDS[i - 3]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [ADDR_W-1:0] frozen;
    frozen = m_irpc;
    bus.pipeline_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.ir_pc !== frozen || bus.instr_valid !== 1'b1 || dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL stall_hold cyc %0d: got pc=%h vec=%h want pc=%h vec=%h",
                           i, bus.ir_pc, dut_vec(), frozen, exp_vec());
      end
    end
    bus.pipeline_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (bus.ir_pc !== ADDR_W'(frozen + ADDR_W'(i)) || bus.instr_valid !== 1'b1 ||
          bus.instr_data !== gmem[ADDR_W'(frozen + ADDR_W'(i))]) begin
        errors++; $display("FAIL stall_resume cyc %0d: got pc=%h v=%b want pc=%h v=1",
                           i, bus.ir_pc, bus.instr_valid, ADDR_W'(frozen + ADDR_W'(i)));
      end
    end
  endtask

  task automatic test_redirect();
    bus.pc_ld = 1'b1; bus.pc_ld_addr = 8'h20;
    tick();
    bus.pc_ld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL redirect_model cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      checks++;
      if (i < 3) begin
        if (bus.instr_valid !== 1'b0) begin
          errors++; $display("FAIL redirect_bubble cyc %0d: valid got %b want 0", i, bus.instr_valid);
        end
      end else if (bus.instr_valid !== 1'b1 || bus.ir_pc !== ADDR_W'(32'h20 + i - 3) ||
                   bus.instr_data !== gmem[ADDR_W'(32'h20 + i - 3)]) begin
        errors++; $display("FAIL redirect_target cyc %0d: got pc=%h v=%b want pc=%h v=1",
                           i, bus.ir_pc, bus.instr_valid, ADDR_W'(32'h20 + i - 3));
      end
    end
  endtask

  task automatic test_flush();
    logic [ADDR_W-1:0] p;
    // Steady state: IR=p, buffer holds p+1, p+2 in flight, fetch PC at p+3.
    p = m_irpc;
    bus.if_id_flush = 1'b1; bus.ir_ld = 1'b1;
    tick();
    bus.if_id_flush = 1'b0;
    checks++;
    if (bus.instr_data !== 32'h0 || bus.instr_valid !== 1'b0) begin
      errors++; $display("FAIL flush_clear: got d=%h v=%b want d=0 v=0", bus.instr_data, bus.instr_valid);
    end
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL flush_model cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
      if (i == 3) begin
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.ir_pc !== ADDR_W'(p + ADDR_W'(3))) begin
          errors++; $display("FAIL flush_resume: got pc=%h v=%b want pc=%h v=1",
                             bus.ir_pc, bus.instr_valid, ADDR_W'(p + ADDR_W'(3)));
        end
      end
    end
  endtask

  task automatic test_halt();
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || dut_vec() !== exp_vec()) begin
      errors++; $display("FAIL halt_done: got done=%b busy=%b vec=%h want done=1 busy=0 vec=%h",
                         bus.done, bus.busy, dut_vec(), exp_vec());
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL halt_pulse: got done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_wrap();
    bus.start = 1'b1; bus.start_pc = 8'hFE;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i >= 3) begin
        checks++;
        if (bus.instr_valid !== 1'b1 || bus.ir_pc !== ADDR_W'(254 + i - 3)) begin
          errors++; $display("FAIL wrap_seq cyc %0d: got pc=%h v=%b want pc=%h v=1",
                             i, bus.ir_pc, bus.instr_valid, ADDR_W'(254 + i - 3));
        end
      end
    end
  endtask

  task automatic test_wr_protect();
    logic [ADDR_W-1:0] a;
    logic [31:0] old;
    a = 8'h10;
    old = gmem[a];
    bus.host_wr_en = 1'b1; bus.host_wr_addr = a; bus.host_wr_data = ~old;
    tick();
    bus.host_wr_en = 1'b0;
    checks++;
    if (bus.wr_err !== 1'b1) begin
      errors++; $display("FAIL wr_err_pulse: got %b want 1", bus.wr_err);
    end
    tick();
    checks++;
    if (bus.wr_err !== 1'b0) begin
      errors++; $display("FAIL wr_err_clear: got %b want 0", bus.wr_err);
    end
    bus.halt_req = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    bus.start = 1'b1; bus.start_pc = a;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if (bus.ir_pc !== a || bus.instr_data !== old) begin
      errors++; $display("FAIL wr_protect_ram: got pc=%h d=%h want pc=%h d=%h", bus.ir_pc, bus.instr_data, a, old);
    end
  endtask

  task automatic test_reset_midrun();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.instr_valid !== 1'b0 || bus.instr_data !== 32'h0) begin
      errors++; $display("FAIL reset_midrun: got busy=%b v=%b d=%h want 0 0 0",
                         bus.busy, bus.instr_valid, bus.instr_data);
    end
    rst_n = 1'b1;
    bus.start = 1'b1; bus.start_pc = '0;
    tick();
    bus.start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i >= 3) begin
        checks++;
        if (bus.ir_pc !== ADDR_W'(i - 3) || bus.instr_data !== WORDS[i - 3]) begin
          errors++; $display("FAIL reset_refetch cyc %0d: got pc=%h d=%h want pc=%h d=%h",
                             i, bus.ir_pc, bus.instr_data, ADDR_W'(i - 3), WORDS[i - 3]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      rst_n               = ($urandom_range(0, 499) != 0);
      bus.pc_cnt          = ($urandom_range(0, 9) != 0);
      bus.ir_ld           = ($urandom_range(0, 3) != 0);
      bus.pipeline_stall  = ($urandom_range(0, 4) == 0);
      bus.pc_ld           = ($urandom_range(0, 29) == 0);
      bus.pc_ld_addr      = ADDR_W'($urandom);
      bus.if_id_flush     = ($urandom_range(0, 29) == 0);
      bus.halt_req        = ($urandom_range(0, 59) == 0);
      bus.start           = ($urandom_range(0, 9) == 0);
      bus.start_pc        = ADDR_W'($urandom);
      bus.host_wr_en      = ($urandom_range(0, 7) == 0);
      bus.host_wr_addr    = ADDR_W'($urandom);
      bus.host_wr_data    = $urandom;
      tick();
      checks++;
      if (dut_vec() !== exp_vec()) begin
        errors++; $display("FAIL random cyc %0d: got %h want %h", i, dut_vec(), exp_vec());
      end
    end
    rst_n = 1'b1;
    set_idle();
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    test_reset();
    test_load_run();
    test_stall();
    test_redirect();
    test_flush();
    test_halt();
    test_wrap();
    test_wr_protect();
    test_reset_midrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
